// File: rtl/result_serializer_if.sv
// Upstream result strobe plus serializer status, bundled for the result_serializer port.
interface result_serializer_if #(
  parameter int unsigned DW    = 5,
  parameter int unsigned DEPTH = 4
) ();
  logic                    valid;
  logic [DW-1:0]           result;
  logic                    clr_ovf;
  logic                    tx_out;
  logic                    busy;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;

  modport master (output valid, result, clr_ovf, input tx_out, busy, count, overflow);
  modport slave  (input valid, result, clr_ovf, output tx_out, busy, count, overflow);
endinterface

// File: rtl/result_serializer.sv
// Buffers strobed results in a small FIFO and ships each one as a start/data(LSB first)/stop
// frame on a single idle-high line.
module result_serializer #(
  parameter int unsigned DW           = 5,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  result_serializer_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BW = (DW > 1) ? $clog2(DW) : 1;
  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DW - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [DW-1:0]  sr_q, sr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           ovf_q, ovf_d;
  logic [DW-1:0]  mem_q [DEPTH];
  logic           pop, push, drop, tick_done;

  // Frame sequencing, FIFO bookkeeping and sticky overflow.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    sr_d      = sr_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    tick_done = (tick_q == TICK_LAST);

    case (state_q)
      IDLE: begin
        tick_d = '0;
        bit_d  = '0;
        tx_d   = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          sr_d    = mem_q[rd_ptr_q];
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tick_done) begin
          tick_d  = '0;
          bit_d   = '0;
          tx_d    = sr_q[0];
          state_d = DATA;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      DATA: begin
        if (tick_done) begin
          tick_d = '0;
          if (bit_q == BIT_LAST) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            sr_d  = sr_q >> 1;
            tx_d  = sr_d[0];
            bit_d = bit_q + BW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      STOP: begin
        if (tick_done) begin
          tick_d = '0;
          // Back-to-back frames: occupancy is judged before this edge's push.
          if (count_q != '0) begin
            pop     = 1'b1;
            sr_d    = mem_q[rd_ptr_q];
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    push     = bus.valid && ((count_q != FULL) || pop);
    drop     = bus.valid && (count_q == FULL) && !pop;
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    ovf_d    = drop ? 1'b1 : (bus.clr_ovf ? 1'b0 : ovf_q);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      bit_q    <= '0;
      sr_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      sr_q     <= sr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      if (push) mem_q[wr_ptr_q] <= bus.result;
    end
  end

  assign bus.tx_out   = tx_q;
  assign bus.busy     = busy_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_result_serializer.sv
// Randomized bench for result_serializer; expected line/status come from a frame-schedule model.
module tb_result_serializer;
  localparam int unsigned DW = 5, DEPTH = 4, CPB = 2;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int FL = (DW + 2) * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  result_serializer_if #(.DW(DW), .DEPTH(DEPTH)) bus ();
  result_serializer #(.DW(DW), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Each accepted result is a frame occupying edges [s, s+FL).
  typedef struct { int s; logic [DW-1:0] d; } frame_t;
  frame_t fq[$];
  int cyc = 0;
  int last_s = -1000;
  int n_cmp = 0;
  int n_err = 0;
  logic m_tx = 1'b1, m_busy = 1'b0, m_ovf = 1'b0;
  logic [CW-1:0] m_cnt = '0;

  task automatic model_reset();
    fq.delete();
    last_s = -1000;
    m_ovf = 1'b0;
    m_tx = 1'b1; m_busy = 1'b0; m_cnt = '0;
  endtask

  // Advance one clock edge and update the expected outputs for the cycle that follows it.
  task automatic step();
    int pending, k, s;
    bit pop_now, dropped;
    frame_t f;
    @(posedge clk); #1;
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pending = 0; pop_now = 0; dropped = 0;
    foreach (fq[i]) begin
      if (fq[i].s >= cyc) pending++;
      if (fq[i].s == cyc) pop_now = 1;
    end
    if (bus.valid) begin
      if (pending < int'(DEPTH) || pop_now) begin
        s = (cyc + 1 > last_s + FL) ? cyc + 1 : last_s + FL;
        f.s = s; f.d = bus.result;
        fq.push_back(f);
        last_s = s;
      end else dropped = 1;
    end
    if (dropped) m_ovf = 1'b1;
    else if (bus.clr_ovf) m_ovf = 1'b0;
    while (fq.size() > 0 && fq[0].s + FL <= cyc) void'(fq.pop_front());
    m_tx = 1'b1; m_busy = 1'b0; m_cnt = '0;
    foreach (fq[i]) begin
      if (fq[i].s > cyc) m_cnt = m_cnt + CW'(1);
      else if (cyc < fq[i].s + FL) begin
        m_busy = 1'b1;
        k = (cyc - fq[i].s) / CPB;
        m_tx = (k == 0) ? 1'b0 : (k <= int'(DW)) ? fq[i].d[k-1] : 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({bus.tx_out, bus.busy, bus.count, bus.overflow} !== {1'b1, 1'b0, CW'(0), 1'b0}) begin
        n_err++;
        $display("FAIL reset: tx/busy/cnt/ovf got %b/%b/%0d/%b want 1/0/0/0",
                 bus.tx_out, bus.busy, bus.count, bus.overflow);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({bus.tx_out, bus.busy, bus.count, bus.overflow} !== {m_tx, m_busy, m_cnt, m_ovf}) begin
        n_err++;
        $display("FAIL reset_idle cyc %0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", cyc,
                 bus.tx_out, bus.busy, bus.count, bus.overflow, m_tx, m_busy, m_cnt, m_ovf);
      end
    end
  endtask

  task automatic test_single();
    logic [13:0] pat, exp_pat;
    int busy_n;
    pat = '0; busy_n = 0;
    exp_pat = 14'b11110011110000;
    bus.valid = 1'b1; bus.result = 5'b10110;
    step();
    bus.valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.result = DW'($urandom);
      step();
      if (i < 14) pat[i] = bus.tx_out;
      if (bus.busy) busy_n++;
      n_cmp++;
      if ({bus.tx_out, bus.busy, bus.count, bus.overflow} !== {m_tx, m_busy, m_cnt, m_ovf}) begin
        n_err++;
        $display("FAIL single cyc %0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", cyc,
                 bus.tx_out, bus.busy, bus.count, bus.overflow, m_tx, m_busy, m_cnt, m_ovf);
      end
    end
    n_cmp++;
    if (pat !== exp_pat || busy_n != 14) begin
      n_err++;
      $display("FAIL single_frame: line %b busy %0d want %b busy 14", pat, busy_n, exp_pat);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals [3];
    int busy_n, peak;
    vals[0] = 5'h01; vals[1] = 5'h1F; vals[2] = 5'h0A;
    busy_n = 0; peak = 0;
    for (int i = 0; i < 53; i++) begin
      bus.valid = (i < 3);
      bus.result = (i < 3) ? vals[i] : DW'($urandom);
      step();
      if (bus.busy) busy_n++;
      if (int'(bus.count) > peak) peak = int'(bus.count);
      n_cmp++;
      if ({bus.tx_out, bus.busy, bus.count, bus.overflow} !== {m_tx, m_busy, m_cnt, m_ovf}) begin
        n_err++;
        $display("FAIL back_to_back cyc %0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", cyc,
                 bus.tx_out, bus.busy, bus.count, bus.overflow, m_tx, m_busy, m_cnt, m_ovf);
      end
    end
    bus.valid = 1'b0;
    n_cmp++;
    if (busy_n != 42 || peak != 2) begin
      n_err++;
      $display("FAIL back_to_back_totals: busy %0d peak %0d want busy 42 peak 2", busy_n, peak);
    end
  endtask

  task automatic test_overflow();
    int busy_n, peak;
    busy_n = 0; peak = 0;
    for (int i = 0; i < 80; i++) begin
      bus.valid = (i < 6);
      bus.result = DW'($urandom);
      step();
      if (bus.busy) busy_n++;
      if (int'(bus.count) > peak) peak = int'(bus.count);
      n_cmp++;
      if ({bus.tx_out, bus.busy, bus.count, bus.overflow} !== {m_tx, m_busy, m_cnt, m_ovf}) begin
        n_err++;
        $display("FAIL overflow cyc %0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", cyc,
                 bus.tx_out, bus.busy, bus.count, bus.overflow, m_tx, m_busy, m_cnt, m_ovf);
      end
    end
    bus.valid = 1'b0;
    n_cmp++;
    if (busy_n != 5 * FL || peak != int'(DEPTH) || bus.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_totals: busy %0d peak %0d ovf %b want busy %0d peak %0d ovf 1",
               busy_n, peak, bus.overflow, 5 * FL, DEPTH);
    end
  endtask

  task automatic test_clr_ovf();
    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    n_cmp++;
    if (bus.overflow !== 1'b0 || m_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL clr_ovf: overflow got %b want 0", bus.overflow);
    end
    for (int i = 0; i < 12; i++) begin
      bus.valid = (i < 6);
      bus.clr_ovf = (i == 5);
      bus.result = DW'($urandom);
      step();
      n_cmp++;
      if ({bus.tx_out, bus.busy, bus.count, bus.overflow} !== {m_tx, m_busy, m_cnt, m_ovf}) begin
        n_err++;
        $display("FAIL clr_vs_drop cyc %0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", cyc,
                 bus.tx_out, bus.busy, bus.count, bus.overflow, m_tx, m_busy, m_cnt, m_ovf);
      end
      if (i == 5) begin
        n_cmp++;
        if (bus.overflow !== 1'b1) begin
          n_err++;
          $display("FAIL clr_with_drop: overflow got %b want 1", bus.overflow);
        end
      end
    end
    bus.valid = 1'b0; bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    for (int i = 0; i < 80; i++) step();
  endtask

  task automatic test_full_accept();
    bit fired, want;
    fired = 0;
    for (int i = 0; i < 5; i++) begin
      bus.valid = 1'b1; bus.result = DW'($urandom);
      step();
    end
    bus.valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      want = 0;
      foreach (fq[j]) if (fq[j].s == cyc + 1) want = 1;
      want = want && !fired && (m_cnt == CW'(DEPTH));
      bus.valid = want; bus.result = DW'($urandom);
      step();
      bus.valid = 1'b0;
      n_cmp++;
      if ({bus.tx_out, bus.busy, bus.count, bus.overflow} !== {m_tx, m_busy, m_cnt, m_ovf}) begin
        n_err++;
        $display("FAIL full_accept cyc %0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", cyc,
                 bus.tx_out, bus.busy, bus.count, bus.overflow, m_tx, m_busy, m_cnt, m_ovf);
      end
      if (want) begin
        fired = 1;
        n_cmp++;
        if (bus.count !== CW'(DEPTH) || bus.overflow !== 1'b0) begin
          n_err++;
          $display("FAIL stop_edge_push: count %0d ovf %b want %0d/0", bus.count, bus.overflow, DEPTH);
        end
      end
    end
    n_cmp++;
    if (!fired) begin
      n_err++;
      $display("FAIL stop_edge_push: full STOP-completion edge never reached, got 0 want 1");
    end
    for (int i = 0; i < 80; i++) step();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) begin
      bus.valid = (i < 2); bus.result = DW'($urandom);
      step();
    end
    bus.valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({bus.tx_out, bus.busy, bus.count, bus.overflow} !== {1'b1, 1'b0, CW'(0), 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got %b/%b/%0d/%b want 1/0/0/0",
               bus.tx_out, bus.busy, bus.count, bus.overflow);
    end
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      bus.valid = (i == 5); bus.result = DW'($urandom);
      step();
      n_cmp++;
      if ({bus.tx_out, bus.busy, bus.count, bus.overflow} !== {m_tx, m_busy, m_cnt, m_ovf}) begin
        n_err++;
        $display("FAIL after_reset cyc %0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", cyc,
                 bus.tx_out, bus.busy, bus.count, bus.overflow, m_tx, m_busy, m_cnt, m_ovf);
      end
    end
    bus.valid = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.valid = ($urandom_range(0, 3) == 0);
      bus.result = DW'($urandom);
      bus.clr_ovf = ($urandom_range(0, 15) == 0);
      step();
      n_cmp++;
      if ({bus.tx_out, bus.busy, bus.count, bus.overflow} !== {m_tx, m_busy, m_cnt, m_ovf}) begin
        n_err++;
        $display("FAIL random cyc %0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", cyc,
                 bus.tx_out, bus.busy, bus.count, bus.overflow, m_tx, m_busy, m_cnt, m_ovf);
      end
    end
    bus.valid = 1'b0; bus.clr_ovf = 1'b0;
  endtask

  initial begin
    bus.valid = 1'b0;
    bus.result = '0;
    bus.clr_ovf = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_clr_ovf();
    test_full_accept();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
